// File: rtl/col_mac_pkg.sv
// Shared constants and width helpers for the column MAC array and the
// partial-sum adder tree that consumes its packed lane outputs.
package col_mac_pkg;

    localparam int DEF_BIT_WIDTH     = 8;
    localparam int DEF_NO_COL_KERNEL = 5;
    localparam int DEF_ACC_GUARD     = 4;

    // Accumulator width: full signed product plus guard bits for summing beats.
    function automatic int acc_width(input int bit_width, input int guard);
        return 2 * bit_width + guard;
    endfunction

    // Kernel-column counter width; never narrower than one bit.
    function automatic int kcnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lane k of a packed column occupies bits [lane_lsb(k, w) +: w].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    localparam int DEF_ACC_WIDTH  = acc_width(DEF_BIT_WIDTH, DEF_ACC_GUARD);
    localparam int DEF_WCOL_WIDTH = DEF_BIT_WIDTH * DEF_NO_COL_KERNEL;
    localparam int DEF_ACOL_WIDTH = DEF_ACC_WIDTH * DEF_NO_COL_KERNEL;
    localparam int DEF_KCNT_WIDTH = kcnt_width(DEF_NO_COL_KERNEL);

endpackage

// File: rtl/col_mac_lane.sv
// One lane of the column MAC: registered signed product (stage 1) feeding a
// signed accumulator (stage 2). Build option COL_MAC_SAT_EN makes the stage-2
// add saturate instead of wrapping.
module col_mac_lane
    import col_mac_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load_prod,
    input  logic                 i_acc_en,
    input  logic                 i_acc_first,
    input  logic [BIT_WIDTH-1:0] i_weight,
    input  logic [BIT_WIDTH-1:0] i_pix,
    output logic [ACC_WIDTH-1:0] o_acc
);

    localparam int PROD_W = 2 * BIT_WIDTH;

    logic signed [PROD_W-1:0]    w_w_ext;
    logic signed [PROD_W-1:0]    w_p_ext;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [PROD_W-1:0]    r_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_add;
    logic signed [ACC_WIDTH-1:0] r_acc;

    assign w_w_ext    = PROD_W'($signed(i_weight));
    assign w_p_ext    = PROD_W'($signed(i_pix));
    assign w_prod     = w_w_ext * w_p_ext;
    assign w_prod_ext = ACC_WIDTH'(r_prod);
    assign w_sum      = r_acc + w_prod_ext;

`ifdef COL_MAC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic w_ovf;

    // Overflow only when both addends share a sign the sum does not.
    assign w_ovf = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                   (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    assign w_add = w_ovf ? (r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
    assign w_add = w_sum;
`endif

    // Stage 1: capture the product of an accepted beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prod <= '0;
        end else if (i_load_prod) begin
            r_prod <= w_prod;
        end
    end

    // Stage 2: first beat loads, later beats add onto whatever is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= i_acc_first ? w_prod_ext : w_add;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/col_mac_array.sv
// Column MAC array: broadcasts one pixel across NO_COL_KERNEL weight lanes,
// accumulates per lane across beats, and emits the lane sums with the
// kernel-column index of the closing beat. Two-stage pipeline with a single
// global stall driven by output backpressure.
// Build option: COL_MAC_SAT_EN selects saturating accumulation (default wraps).
module col_mac_array
    import col_mac_pkg::*;
#(
    parameter  int BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter  int NO_COL_KERNEL = DEF_NO_COL_KERNEL,
    parameter  int ACC_GUARD     = DEF_ACC_GUARD,
    localparam int ACC_WIDTH     = acc_width(BIT_WIDTH, ACC_GUARD),
    localparam int KCNT_W        = kcnt_width(NO_COL_KERNEL)
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [BIT_WIDTH*NO_COL_KERNEL-1:0] i_weight_col,
    input  logic [BIT_WIDTH-1:0]               i_pix,
    input  logic                               i_first,
    input  logic                               i_last,
    input  logic                               i_new_chan,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [ACC_WIDTH*NO_COL_KERNEL-1:0] o_acc_col,
    output logic [KCNT_W-1:0]                  o_kercol_idx
);

    localparam logic [KCNT_W-1:0] LAST_IDX = KCNT_W'(NO_COL_KERNEL - 1);

    logic              r_rst_meta;
    logic              r_rst_sync;
    logic              w_rst_n;
    logic              w_en;
    logic              w_accept;
    logic [KCNT_W-1:0] w_beat_idx;
    logic [KCNT_W-1:0] r_cnt;
    logic              r_s1_valid;
    logic              r_s1_first;
    logic              r_s1_last;
    logic [KCNT_W-1:0] r_s1_idx;
    logic              r_o_valid;
    logic [KCNT_W-1:0] r_kidx;

    // Reset asserts asynchronously, releases two clock edges later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n    = r_rst_sync;
    assign w_en       = !(r_o_valid && !i_ready);
    assign o_ready    = w_en;
    assign w_accept   = i_valid && w_en;
    assign w_beat_idx = i_new_chan ? '0 : r_cnt;

    // Kernel-column counter: advances per accepted beat, wraps at the last column.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= (w_beat_idx == LAST_IDX) ? '0 : w_beat_idx + KCNT_W'(1);
        end
    end

    // Stage-1 flag pipe travelling alongside the registered products.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_idx   <= '0;
        end else if (w_en) begin
            r_s1_valid <= i_valid;
            if (w_accept) begin
                r_s1_first <= i_first;
                r_s1_last  <= i_last;
                r_s1_idx   <= w_beat_idx;
            end
        end
    end

    // Stage-2 result flags; a landing last-beat keeps o_valid high back-to-back.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_o_valid <= 1'b0;
            r_kidx    <= '0;
        end else if (w_en) begin
            r_o_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_kidx <= r_s1_idx;
            end
        end
    end

    assign o_valid      = r_o_valid;
    assign o_kercol_idx = r_kidx;

    for (genvar k = 0; k < NO_COL_KERNEL; k++) begin : g_lane
        col_mac_lane #(
            .BIT_WIDTH (BIT_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst_n     (w_rst_n),
            .i_load_prod (w_accept),
            .i_acc_en    (w_en && r_s1_valid),
            .i_acc_first (r_s1_first),
            .i_weight    (i_weight_col[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH]),
            .i_pix       (i_pix),
            .o_acc       (o_acc_col[lane_lsb(k, ACC_WIDTH) +: ACC_WIDTH])
        );
    end

endmodule

// File: tb/tb_col_mac_array.sv
// Bench for col_mac_array: transaction-level lane model with a result queue,
// per-cycle compare on the output handshake, directed literal checks and a
// randomized phase with random output backpressure.
`timescale 1ns/1ps
module tb_col_mac_array;

    localparam int BW = 8;
    localparam int NK = 5;
    localparam int AG = 4;
    localparam int AW = 2 * BW + AG;
    localparam int KW = 3;
    localparam longint MODV = 64'sd1 <<< AW;
    localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW - 1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [BW*NK-1:0]  i_weight_col = '0;
    logic [BW-1:0]     i_pix = '0;
    logic              i_first = 1'b0;
    logic              i_last = 1'b0;
    logic              i_new_chan = 1'b0;
    logic              o_valid;
    logic              i_ready = 1'b1;
    logic [AW*NK-1:0]  o_acc_col;
    logic [KW-1:0]     o_kercol_idx;

    int n_chk = 0;
    int n_fail = 0;

    bit rdy_force = 1'b1;
    bit rdy_val = 1'b1;

    typedef struct {
        logic [AW*NK-1:0] acc;
        logic [KW-1:0]    idx;
    } res_t;

    longint        m_acc[NK];
    int            m_cnt = 0;
    res_t          exp_q[$];
    logic [KW-1:0] got_idx_q[$];
    res_t          r_pop;
    bit            have_prev = 1'b0;
    logic [AW*NK-1:0] prev_acc;
    logic [KW-1:0]    prev_idx;

    always #5 clk = ~clk;

    col_mac_array #(
        .BIT_WIDTH     (BW),
        .NO_COL_KERNEL (NK),
        .ACC_GUARD     (AG)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_weight_col (i_weight_col),
        .i_pix        (i_pix),
        .i_first      (i_first),
        .i_last       (i_last),
        .i_new_chan   (i_new_chan),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_acc_col    (o_acc_col),
        .o_kercol_idx (o_kercol_idx)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Fit an exact sum into the accumulator's range (wrap or clamp).
    function automatic longint fit(input longint v);
        longint m;
`ifdef COL_MAC_SAT_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`else
        m = v % MODV;
        if (m < 0) m += MODV;
        if (m > MAXV) m -= MODV;
        return m;
`endif
    endfunction

    function automatic logic [AW*NK-1:0] pack_same(input longint v);
        logic [AW*NK-1:0] t;
        for (int k = 0; k < NK; k++) t[k*AW +: AW] = v[AW-1:0];
        return t;
    endfunction

    task automatic model_accept();
        int idx;
        res_t r;
        logic signed [BW-1:0] ws;
        logic signed [BW-1:0] ps;
        longint t;
        idx = i_new_chan ? 0 : m_cnt;
        m_cnt = (idx == NK - 1) ? 0 : idx + 1;
        ps = i_pix;
        for (int k = 0; k < NK; k++) begin
            ws = i_weight_col[k*BW +: BW];
            t = longint'(ws) * longint'(ps);
            m_acc[k] = i_first ? fit(t) : fit(m_acc[k] + t);
        end
        if (i_last) begin
            for (int k = 0; k < NK; k++) begin
                t = m_acc[k];
                r.acc[k*AW +: AW] = t[AW-1:0];
            end
            r.idx = KW'(idx);
            exp_q.push_back(r);
        end
    endtask

    // Random or forced output backpressure, changed just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            i_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Per-cycle compare against the model; sampled at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) m_acc[k] = 0;
            m_cnt = 0;
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            chk("o_ready_rule", o_ready, !(o_valid && !i_ready));
            if (have_prev) begin
                chk("stall_acc_hold", o_acc_col, prev_acc);
                chk("stall_idx_hold", o_kercol_idx, prev_idx);
            end
            have_prev = o_valid && !i_ready;
            prev_acc = o_acc_col;
            prev_idx = o_kercol_idx;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 1'b1, 1'b0);
                end else begin
                    r_pop = exp_q.pop_front();
                    chk("acc_col", o_acc_col, r_pop.acc);
                    chk("kercol_idx", o_kercol_idx, r_pop.idx);
                    got_idx_q.push_back(o_kercol_idx);
                end
            end
            if (i_valid && o_ready) model_accept();
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one beat (call just after a rising edge); returns just after its accept edge.
    task automatic send(input logic [BW*NK-1:0] w, input logic [BW-1:0] pix,
                        input bit first, input bit last, input bit newch);
        int n = 0;
        i_valid = 1'b1;
        i_weight_col = w;
        i_pix = pix;
        i_first = first;
        i_last = last;
        i_new_chan = newch;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last = 1'b0;
        i_new_chan = 1'b0;
    endtask

    // Returns at a falling edge with o_valid high, or records a timeout.
    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!o_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!o_valid) chk({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_acc", o_acc_col, '0);
        chk("rst_idx", o_kercol_idx, '0);
        chk("rst_ready", o_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [BW*NK-1:0] rand_w();
        logic [BW*NK-1:0] w;
        for (int k = 0; k < NK; k++) w[k*BW +: BW] = BW'($urandom);
        return w;
    endfunction

    initial begin
        logic [BW*NK-1:0] w;
        logic [AW*NK-1:0] e;
        logic [AW*NK-1:0] snap;
        int exp_a[7];
        int exp_b[7];

        do_reset();

        // Single beat, first and last together: lanes k+1 times 3, two-cycle latency.
        for (int k = 0; k < NK; k++) w[k*BW +: BW] = BW'(k + 1);
        send(w, 8'd3, 1'b1, 1'b1, 1'b1);
        chk("t1_not_yet", o_valid, 1'b0);
        sync();
        chk("t1_latency", o_valid, 1'b1);
        for (int k = 0; k < NK; k++) e[k*AW +: AW] = AW'(3 * (k + 1));
        chk("t1_acc", o_acc_col, e);
        chk("t1_idx", o_kercol_idx, 3'd0);

        // Signed extremes over three beats: 3 * 16384 per lane.
        send({NK{8'h80}}, 8'h80, 1'b1, 1'b0, 1'b1);
        send({NK{8'h80}}, 8'h80, 1'b0, 1'b0, 1'b0);
        send({NK{8'h80}}, 8'h80, 1'b0, 1'b1, 1'b0);
        wait_valid("t2");
        chk("t2_acc", o_acc_col, pack_same(49152));
        chk("t2_idx", o_kercol_idx, 3'd2);
        sync();

        // Backpressure: result held four cycles, a queued beat waits, then both drain.
        rdy_val = 1'b0;
        sync();
        sync();
        send(rand_w(), 8'($urandom), 1'b1, 1'b1, 1'b0);
        wait_valid("t3");
        snap = o_acc_col;
        fork
            send(rand_w(), 8'($urandom), 1'b1, 1'b1, 1'b0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("t3_ready_low", o_ready, 1'b0);
                    chk("t3_acc_stable", o_acc_col, snap);
                end
                rdy_val = 1'b1;
            end
        join
        wait_valid("t3b");
        sync();
        repeat (3) sync();

        // Column counter wrap from reset, then restarts on new-channel beats.
        do_reset();
        exp_a = '{0, 1, 2, 3, 4, 0, 1};
        exp_b = '{0, 1, 0, 1, 2, 3, 4};
        got_idx_q.delete();
        for (int i = 0; i < 7; i++) send(rand_w(), 8'($urandom), 1'b1, 1'b1, 1'b0);
        repeat (4) sync();
        chk("t4a_count", got_idx_q.size(), 7);
        for (int i = 0; i < 7 && i < got_idx_q.size(); i++) chk("t4a_idx", got_idx_q[i], exp_a[i]);
        got_idx_q.delete();
        for (int i = 0; i < 7; i++) send(rand_w(), 8'($urandom), 1'b1, 1'b1, (i == 0 || i == 2));
        repeat (4) sync();
        chk("t4b_count", got_idx_q.size(), 7);
        for (int i = 0; i < 7 && i < got_idx_q.size(); i++) chk("t4b_idx", got_idx_q[i], exp_b[i]);

        // Overflow: 32 beats of 16384 reach exactly 2^19.
        for (int i = 0; i < 32; i++) send({NK{8'h80}}, 8'h80, (i == 0), (i == 31), (i == 0));
        wait_valid("t5");
`ifdef COL_MAC_SAT_EN
        chk("t5_acc_sat", o_acc_col, pack_same(524287));
`else
        chk("t5_acc_wrap", o_acc_col, pack_same(-524288));
`endif
        chk("t5_idx", o_kercol_idx, 3'd1);
        sync();
        repeat (2) sync();

        // Reset in the middle of an accumulation, then a clean single-beat result.
        send({NK{8'd7}}, 8'd9, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        chk("t6_partial_nonzero", (o_acc_col != '0), 1'b1);
        do_reset();
        send({NK{8'd2}}, 8'hFD, 1'b1, 1'b1, 1'b0);
        wait_valid("t6");
        chk("t6_acc", o_acc_col, pack_same(-6));
        chk("t6_idx", o_kercol_idx, 3'd0);
        sync();

        // Randomized beats and flags under random backpressure.
        rdy_force = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                sync();
            end else begin
                send(rand_w(), 8'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            end
        end
        rdy_force = 1'b1;
        rdy_val = 1'b1;
        repeat (10) sync();
        chk("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
